// File: rtl/vec_operand_fetch.sv
// rtl/vec_operand_fetch.sv - vector operand fetch/issue stage with register file, scoreboard and writeback bypass
// Decodes one instruction per cycle, reads Vs/Vt with writeback bypass, stalls on pending Vs/Vt/Vd.
`timescale 1ns/1ps
module vec_operand_fetch #(
  parameter int NUM_VREGS = 8,
  parameter int VLEN      = 256,
  localparam int AW       = $clog2(NUM_VREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  output logic            instr_ready,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [VLEN-1:0] wb_data,
  output logic [VLEN-1:0] op_1,
  output logic [VLEN-1:0] op_2,
  output logic [3:0]      opcode,
  output logic [AW-1:0]   dest,
  output logic            issue_valid,
  output logic [7:0]      illegal_cnt
);

  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  logic [VLEN-1:0]      vreg [NUM_VREGS];
  logic [NUM_VREGS-1:0] pending;
  logic [NUM_VREGS-1:0] pend_eff;
  logic [NUM_VREGS-1:0] pending_next;

  logic [3:0]      dec_op;
  logic [AW-1:0]   vd, vs, vt;
  logic            is_vadd, is_nop, hazard, accept;
  logic [VLEN-1:0] rd_s, rd_t;
  logic            unused_bits;

  assign dec_op      = instr[15:12];
  assign vd          = instr[11:9];
  assign vs          = instr[8:6];
  assign vt          = instr[5:3];
  assign unused_bits = ^instr[2:0];

  assign is_vadd = (dec_op == OP_VADD);
  assign is_nop  = (dec_op == OP_NOP);

  // A register being written back this cycle is already resolved for hazard purposes.
  always_comb begin
    pend_eff = pending;
    if (wb_en) pend_eff[wb_addr] = 1'b0;
  end

  assign hazard      = is_vadd & (pend_eff[vs] | pend_eff[vt] | pend_eff[vd]);
  assign instr_ready = rst | ~hazard;
  assign accept      = instr_valid & instr_ready & ~rst;

  assign rd_s = (wb_en && wb_addr == vs) ? wb_data : vreg[vs];
  assign rd_t = (wb_en && wb_addr == vt) ? wb_data : vreg[vt];

  // Set after clear so a same-cycle writeback and reissue to Vd leaves it pending.
  always_comb begin
    pending_next = pending;
    if (wb_en) pending_next[wb_addr] = 1'b0;
    if (accept && is_vadd) pending_next[vd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VREGS; i++) vreg[i] <= '0;
      pending <= '0;
    end else begin
      if (wb_en) vreg[wb_addr] <= wb_data;
      pending <= pending_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_1        <= '0;
      op_2        <= '0;
      opcode      <= OP_NOP;
      dest        <= '0;
      issue_valid <= 1'b0;
      illegal_cnt <= 8'd0;
    end else begin
      // Bubbles and non-VADD instructions present NOP since the ALU samples every clock.
      opcode      <= OP_NOP;
      issue_valid <= 1'b0;
      if (accept && is_vadd) begin
        op_1        <= rd_s;
        op_2        <= rd_t;
        opcode      <= OP_VADD;
        dest        <= vd;
        issue_valid <= 1'b1;
      end
      if (accept && !is_vadd && !is_nop && illegal_cnt != 8'hFF)
        illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: doc/vec_operand_fetch.md
# vec_operand_fetch

Operand-fetch and issue stage directly upstream of the vector ALU. Accepts one 16-bit instruction per cycle over a valid/ready handshake, decodes it, reads two 256-bit sources from an internal 8-entry vector register file, and drives registered `op_1`, `op_2` and `opcode` into the ALU. Also owns the writeback port into the register file and a per-register scoreboard that stalls read-after-write and write-after-write hazards against in-flight ALU results.

## Interface
- `NUM_VREGS`, 8: vector register count; register index width is log2, 3 bits at default.
- `VLEN`, 256: vector width in bits, 16 lanes × 16-bit half floats.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `instr_valid`  in  1  upstream has an instruction on `instr`.
- `instr`  in  16  instruction; [15:12] opcode, [11:9] Vd, [8:6] Vs, [5:3] Vt, [2:0] ignored.
- `instr_ready`  out  1  stage can accept `instr` this cycle; combinational.
- `wb_en`  in  1  ALU result writeback strobe.
- `wb_addr`  in  3  writeback destination register.
- `wb_data`  in  256  writeback data.
- `op_1`  out  256  first ALU operand, from Vs; registered.
- `op_2`  out  256  second ALU operand, from Vt; registered.
- `opcode`  out  4  ALU opcode; registered.
- `dest`  out  3  destination register of the issued op; registered.
- `issue_valid`  out  1  outputs carry a real issued op this cycle.
- `illegal_cnt`  out  8  saturating count of unsupported opcodes.

## Operation
- Opcode encodings: VADD = 4'b0000, NOP = 4'b1111.
- Register file: `NUM_VREGS` × 256 bits. Written when `wb_en` is high.
- Scoreboard: one pending bit per register.
- Handshake: an instruction is accepted when `instr_valid && instr_ready`.
- `instr_ready` = !hazard. For VADD, hazard = pending[Vs] | pending[Vt] | pending[Vd]. Writeback clearing in the current cycle counts as not pending (see bypass). NOP and illegal opcodes never hazard.
- Accepted VADD:
  - op_1 = V[Vs], op_2 = V[Vt], opcode = 0000, dest = Vd, issue_valid = 1.
  - pending[Vd] is set.
- Accepted NOP:
  - opcode = 1111, issue_valid = 0, operands hold previous values.
- Accepted opcode 0001–1110 (not yet supported by this stage):
  - Issued as NOP, issue_valid = 0.
  - illegal_cnt increments, saturating at 255.
- No acceptance in a cycle: opcode = 1111, issue_valid = 0, op_1/op_2/dest hold. The ALU samples `opcode` every clock, so a bubble must present NOP.
- Writeback:
  - Writes V[wb_addr] = wb_data and clears pending[wb_addr].
  - A writeback to a non-pending register is legal; it just writes.
- Bypass: when `wb_en` and `wb_addr` equals Vs and/or Vt of the accepted instruction in the same cycle, the operand takes `wb_data`, not the stale array value. The matching pending bit is treated as clear for the hazard check.
- Same-cycle clear and set on the same register (writeback to Vd while a new VADD to Vd issues): the set wins and pending[Vd] = 1 afterwards.
- Vs = Vt is legal; both operands read the same register.

## Timing
- Reset (asynchronous assert, clears immediately):
  - op_1 = 0, op_2 = 0, opcode = 4'b1111, dest = 0, issue_valid = 0, illegal_cnt = 0.
  - All registers = 0, all pending bits = 0.
  - `instr_ready` = 1 while `rst` is high; accepts nothing until deassert.
- Reset mid-operation discards in-flight ops. A `wb_en` arriving after reset writes normally but clears an already-clear bit.
- Issue latency: instruction accepted at edge N → op_1/op_2/opcode valid after edge N, for exactly one cycle. The ALU registers its result at edge N+1; the downstream writeback strobe follows.
- Back-to-back independent VADDs issue one per cycle.
- Dependent VADD stalls until the cycle its source writeback arrives, then issues with bypassed data. Zero bubble beyond writeback arrival.
- `instr` must be held stable while `instr_valid && !instr_ready`.

## Test plan
- Reset: assert `rst` with nonzero state → all outputs at reset values; `opcode` = 1111 and `instr_ready` = 1 immediately.
- Preload then issue:
  - Writeback V1 = {16{16'h3C00}} and V2 = {16{16'h3C00}}.
  - Issue VADD V3,V1,V2 (instr 16'h0650).
  - Expect next cycle: op_1 = op_2 = {16{16'h3C00}}, opcode = 0000, dest = 3, issue_valid = 1, pending[3] = 1.
- RAW stall and bypass:
  - Issue VADD V3,V1,V2, then present VADD V4,V3,V1.
  - `instr_ready` stays 0 until `wb_en` with wb_addr = 3 and wb_data = {16{16'h4000}}.
  - In that cycle ready = 1 and the op issues with op_1 = {16{16'h4000}}.
- WAW: a second VADD to V3 while pending[3] → stalled. Writeback to V3 and the reissue in the same cycle → pending[3] stays 1.
- Illegal opcode: present 16'h1000 → issued as NOP, issue_valid = 0, illegal_cnt = 1. After 300 illegal instructions, illegal_cnt = 255.
- Bubbles and mid-op reset:
  - `instr_valid` = 0 for 3 cycles → opcode = 1111 each cycle, operands hold.
  - Assert `rst` while pending[3] = 1 → pending cleared; a following VADD V5,V3,V3 issues with op_1 = op_2 = 0.
